// File: rtl/display_arbiter_if.sv
// Purpose: bundles the requester-side inputs and display-side outputs of
//          display_arbiter into one port.
// Signals:
//   req              3   per-requester level request, bit i = requester i
//   data0..data2     16  requester digits {d3,d2,d1,d0}, 4 bits each
//   gnt              3   one-hot grant, 3'b000 when idle or switching
//   digit3..digit0   4   digits to the scan controller (digit3 leftmost)
//   busy             1   high while a requester owns the display
// Modports: master = requester/bench side, slave = arbiter side.
interface display_arbiter_if;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [2:0]  gnt;
    logic [3:0]  digit3;
    logic [3:0]  digit2;
    logic [3:0]  digit1;
    logic [3:0]  digit0;
    logic        busy;

    modport master (
        output req, data0, data1, data2,
        input  gnt, digit3, digit2, digit1, digit0, busy
    );

    modport slave (
        input  req, data0, data1, data2,
        output gnt, digit3, digit2, digit1, digit0, busy
    );
endinterface

// File: rtl/display_arbiter.sv
// Purpose: shares a 4-digit 7-segment display between three requesters.
//          Round-robin grant, minimum ownership time before preemption, and
//          one blank cycle at every ownership change. All outputs registered.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of display_arbiter_if (req/data in, gnt/digits/busy out)
module display_arbiter #(
    parameter int unsigned MIN_HOLD    = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter logic [3:0]  BLANK_DIGIT = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    display_arbiter_if.slave  bus
);

    localparam int unsigned DIGITS_W = 16;
    localparam logic [CNT_W-1:0]    HOLD_MAX   = CNT_W'(MIN_HOLD);
    localparam logic [DIGITS_W-1:0] BLANK_WORD = {4{BLANK_DIGIT}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [CNT_W-1:0]    r_hold_cnt, w_hold_nxt;
    logic [1:0]          r_last,     w_last_nxt;
    logic [1:0]          r_owner,    w_owner_nxt;
    logic [2:0]          r_gnt,      w_gnt_nxt;
    logic [DIGITS_W-1:0] r_digits,   w_digits_nxt;
    logic                r_busy,     w_busy_nxt;

    logic [1:0]          w_pick;
    logic [DIGITS_W-1:0] w_owner_data;
    logic                w_owner_req;
    logic                w_other_req;

    // Round-robin winner: search last+1, last+2, last (mod 3).
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] c0, c1, c2;
        case (last)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        if (req[c0])      rr_pick = c0;
        else if (req[c1]) rr_pick = c1;
        else              rr_pick = c2;
    endfunction

    assign w_pick = rr_pick(r_last, bus.req);

    // Owner's digit word, selected by the registered owner index.
    always_comb begin
        case (r_owner)
            2'd0:    w_owner_data = bus.data0;
            2'd1:    w_owner_data = bus.data1;
            default: w_owner_data = bus.data2;
        endcase
    end

    // r_gnt is one-hot of the owner while in OWN, so it masks the owner's bit.
    assign w_owner_req = |(bus.req & r_gnt);
    assign w_other_req = |(bus.req & ~r_gnt);

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold_cnt;
        w_last_nxt   = r_last;
        w_owner_nxt  = r_owner;
        w_gnt_nxt    = r_gnt;
        w_digits_nxt = r_digits;
        w_busy_nxt   = r_busy;

        case (r_state)
            ST_OWN: begin
                // Dropping req wins over hold expiry when both happen together.
                if (!w_owner_req || ((r_hold_cnt == HOLD_MAX) && w_other_req)) begin
                    w_state_nxt  = ST_SWITCH;
                    w_last_nxt   = r_owner;
                    w_gnt_nxt    = 3'b000;
                    w_digits_nxt = BLANK_WORD;
                    w_busy_nxt   = 1'b0;
                end else begin
                    w_digits_nxt = w_owner_data;
                    if (r_hold_cnt != HOLD_MAX) begin
                        w_hold_nxt = r_hold_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                // IDLE and SWITCH arbitrate identically; digits stay blank on entry to OWN.
                w_gnt_nxt    = 3'b000;
                w_digits_nxt = BLANK_WORD;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = ST_IDLE;
                if (|bus.req) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_pick;
                    w_gnt_nxt   = 3'(3'b001 << w_pick);
                    w_hold_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_last     <= 2'd2;
            r_owner    <= 2'd0;
            r_gnt      <= 3'b000;
            r_digits   <= BLANK_WORD;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_last     <= w_last_nxt;
            r_owner    <= w_owner_nxt;
            r_gnt      <= w_gnt_nxt;
            r_digits   <= w_digits_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.digit3 = r_digits[15:12];
    assign bus.digit2 = r_digits[11:8];
    assign bus.digit1 = r_digits[7:4];
    assign bus.digit0 = r_digits[3:0];
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_display_arbiter.sv
// Purpose: directed self-checking bench for display_arbiter (MIN_HOLD=8).
module tb_display_arbiter;

    localparam int unsigned MIN_HOLD = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    display_arbiter_if bus ();

    display_arbiter #(
        .MIN_HOLD    (MIN_HOLD),
        .CNT_W       (16),
        .BLANK_DIGIT (4'hF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        bus.req = 3'b000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.data0 = 16'h1234;
        bus.data1 = 16'hABCD;
        bus.data2 = 16'h5678;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (bus.gnt !== 3'b000 || digits() !== 16'hFFFF || bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset cyc%0d: gnt=%b digits=%h busy=%b, expected 000/ffff/0",
                         i, bus.gnt, digits(), bus.busy);
            end
            step();
        end
    endtask

    task automatic test_basic_grant();
        bus.data0 = 16'h1234;
        bus.req   = 3'b001;
        step();
        n_cmp++;
        if (bus.gnt !== 3'b001 || bus.busy !== 1'b1 || digits() !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL basic_grant: gnt=%b busy=%b digits=%h, expected 001/1/ffff",
                     bus.gnt, bus.busy, digits());
        end
        step();
        n_cmp++;
        if (digits() !== 16'h1234) begin
            n_bad++;
            $display("FAIL basic_digits: got %h expected 1234", digits());
        end
        bus.data0 = 16'h5678;
        #2;
        n_cmp++;
        if (digits() !== 16'h1234) begin
            n_bad++;
            $display("FAIL basic_no_early_update: got %h expected 1234", digits());
        end
        step();
        n_cmp++;
        if (digits() !== 16'h5678) begin
            n_bad++;
            $display("FAIL basic_update: got %h expected 5678", digits());
        end
        bus.req = 3'b000;
        step();
        step();
        n_cmp++;
        if (bus.gnt !== 3'b000 || digits() !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL basic_release: gnt=%b digits=%h, expected 000/ffff", bus.gnt, digits());
        end
    endtask

    task automatic test_min_hold();
        apply_reset();
        bus.data0 = 16'h1234;
        bus.data1 = 16'hABCD;
        bus.req   = 3'b001;
        step();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 2) bus.req = 3'b011;
            n_cmp++;
            if (bus.gnt !== 3'b001 || digits() !== 16'h1234) begin
                n_bad++;
                $display("FAIL min_hold k%0d: gnt=%b digits=%h, expected 001/1234",
                         k, bus.gnt, digits());
            end
        end
        step();
        n_cmp++;
        if (bus.gnt !== 3'b000 || digits() !== 16'hFFFF || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL min_hold_blank: gnt=%b digits=%h busy=%b, expected 000/ffff/0",
                     bus.gnt, digits(), bus.busy);
        end
        step();
        n_cmp++;
        if (bus.gnt !== 3'b010 || digits() !== 16'hFFFF || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL min_hold_handoff: gnt=%b digits=%h busy=%b, expected 010/ffff/1",
                     bus.gnt, digits(), bus.busy);
        end
        step();
        n_cmp++;
        if (digits() !== 16'hABCD) begin
            n_bad++;
            $display("FAIL min_hold_new_digits: got %h expected abcd", digits());
        end
        bus.req = 3'b000;
        step();
        step();
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_gnt [4];
        logic [15:0] exp_dig [4];
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_dig = '{16'h1111, 16'h2222, 16'h3333, 16'h1111};
        apply_reset();
        bus.data0 = 16'h1111;
        bus.data1 = 16'h2222;
        bus.data2 = 16'h3333;
        bus.req   = 3'b111;
        step();
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c <= 8; c++) begin
                n_cmp++;
                if (bus.gnt !== exp_gnt[g] ||
                    digits() !== ((c == 0) ? 16'hFFFF : exp_dig[g])) begin
                    n_bad++;
                    $display("FAIL rr g%0d c%0d: gnt=%b digits=%h, expected %b/%h", g, c,
                             bus.gnt, digits(), exp_gnt[g], (c == 0) ? 16'hFFFF : exp_dig[g]);
                end
                step();
            end
            if (g < 3) begin
                n_cmp++;
                if (bus.gnt !== 3'b000 || digits() !== 16'hFFFF) begin
                    n_bad++;
                    $display("FAIL rr_blank g%0d: gnt=%b digits=%h, expected 000/ffff",
                             g, bus.gnt, digits());
                end
                step();
            end
        end
        bus.req = 3'b000;
        step();
        step();
    endtask

    task automatic test_drop_to_idle();
        apply_reset();
        bus.data1 = 16'h4321;
        bus.req   = 3'b010;
        step();
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if (bus.gnt !== 3'b010) begin
                n_bad++;
                $display("FAIL drop_own k%0d: gnt=%b expected 010", k, bus.gnt);
            end
            step();
        end
        bus.req = 3'b000;
        step();
        n_cmp++;
        if (bus.gnt !== 3'b000 || digits() !== 16'hFFFF || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_switch: gnt=%b digits=%h busy=%b, expected 000/ffff/0",
                     bus.gnt, digits(), bus.busy);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (bus.gnt !== 3'b000 || digits() !== 16'hFFFF || bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL drop_idle k%0d: gnt=%b digits=%h busy=%b, expected 000/ffff/0",
                         k, bus.gnt, digits(), bus.busy);
            end
        end
    endtask

    task automatic test_hold_indefinite();
        apply_reset();
        bus.data0 = 16'h9876;
        bus.req   = 3'b001;
        step();
        for (int k = 0; k < 25; k++) step();
        n_cmp++;
        if (bus.gnt !== 3'b001 || digits() !== 16'h9876 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_indef: gnt=%b digits=%h busy=%b, expected 001/9876/1",
                     bus.gnt, digits(), bus.busy);
        end
        // Drop, then re-raise during the SWITCH cycle: sole requester regranted.
        bus.req = 3'b000;
        step();
        n_cmp++;
        if (bus.gnt !== 3'b000) begin
            n_bad++;
            $display("FAIL regrant_switch: gnt=%b expected 000", bus.gnt);
        end
        bus.req = 3'b001;
        step();
        n_cmp++;
        if (bus.gnt !== 3'b001 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL regrant: gnt=%b busy=%b expected 001/1", bus.gnt, bus.busy);
        end
        bus.req = 3'b000;
        step();
        step();
    endtask

    task automatic test_midop_reset();
        apply_reset();
        bus.data2 = 16'h3456;
        bus.req   = 3'b100;
        step();
        n_cmp++;
        if (bus.gnt !== 3'b100) begin
            n_bad++;
            $display("FAIL midrst_grant: gnt=%b expected 100", bus.gnt);
        end
        step();
        n_cmp++;
        if (digits() !== 16'h3456) begin
            n_bad++;
            $display("FAIL midrst_digits: got %h expected 3456", digits());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.gnt !== 3'b000 || digits() !== 16'hFFFF || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_async: gnt=%b digits=%h busy=%b, expected 000/ffff/0",
                     bus.gnt, digits(), bus.busy);
        end
        step();
        rst_n   = 1'b1;
        bus.req = 3'b111;
        step();
        n_cmp++;
        if (bus.gnt !== 3'b001) begin
            n_bad++;
            $display("FAIL midrst_first: gnt=%b expected 001", bus.gnt);
        end
        bus.req = 3'b000;
        step();
        step();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        bus.req   = 3'b000;
        bus.data0 = 16'h0000;
        bus.data1 = 16'h0000;
        bus.data2 = 16'h0000;
        #3;
        test_reset();
        test_basic_grant();
        test_min_hold();
        test_round_robin();
        test_drop_to_idle();
        test_hold_indefinite();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
